led_row_scheduler: RTL and testbench



---
 rtl/led_row_scheduler.sv | 166 ++++++++++++++++
 tb/tb_led_row_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/led_row_scheduler.sv
`timescale 1ns/1ps
// led_row_scheduler
//   Sits in front of the VGA LED-byte drawer. Two requesters write bytes into
//   a shadow row store through a round-robin arbiter; pending rows are copied
//   into the display store in a single COMMIT cycle at vblank entry so a frame
//   never shows a half-updated picture. During active video the block drives
//   row_led/byte_led from a line/row counter that follows y_px.
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   y_px, activevideo     scan position from the VGA controller
//   reqN_valid/row/byte   write request from requester N (N = 0, 1)
//   reqN_ready            combinational grant; transfer when valid & ready
//   byte_led, row_led     registered drawer inputs
//   commit                high during the COMMIT cycle
//   bad_row               one-cycle pulse after an accepted write to row >= NUM_ROWS
module led_row_scheduler #(
  parameter int NUM_ROWS = 6,
  parameter int HEIGHT   = 80,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] y_px,
  input  logic       activevideo,
  input  logic       req0_valid,
  input  logic [2:0] req0_row,
  input  logic [7:0] req0_byte,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_row,
  input  logic [7:0] req1_byte,
  output logic       req1_ready,
  output logic [7:0] byte_led,
  output logic [2:0] row_led,
  output logic       commit,
  output logic       bad_row
);

  localparam int         LW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);

  typedef enum logic [1:0] {ST_SCAN, ST_VBLANK, ST_COMMIT} state_t;

  state_t state, state_nx;

  logic                      in_vblank, prev_vblank, vblank_rise;
  logic                      accept_en;
  logic                      prio;          // 0: requester 0 wins a tie
  logic                      gnt0, gnt1, wr_en, row_ok;
  logic [2:0]                wr_row;
  logic [7:0]                wr_data;
  logic [NUM_ROWS-1:0][7:0]  shadow, display;
  logic [NUM_ROWS-1:0]       pending;
  logic [9:0]                y_prev;
  logic [LW-1:0]             line_cnt;
  logic [2:0]                row_cnt;
  logic [7:0]                cur_byte;

  // ---------------- vblank edge detect ----------------
  assign in_vblank   = (y_px >= V_ACT);
  assign vblank_rise = in_vblank & ~prev_vblank;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_vblank <= 1'b0;
    else        prev_vblank <= in_vblank;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_VBLANK;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_SCAN:   if (vblank_rise) state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_VBLANK;
      ST_VBLANK: if (!in_vblank) state_nx = ST_SCAN;
      default:   state_nx = ST_VBLANK;
    endcase
  end

  always_comb begin
    commit    = (state == ST_COMMIT);
    accept_en = (state != ST_COMMIT);
  end

  // ---------------- arbiter ----------------
  assign gnt0       = accept_en & req0_valid & (~req1_valid | ~prio);
  assign gnt1       = accept_en & req1_valid & (~req0_valid |  prio);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign wr_en      = gnt0 | gnt1;
  assign wr_row     = gnt0 ? req0_row  : req1_row;
  assign wr_data    = gnt0 ? req0_byte : req1_byte;
  // Widened compare so NUM_ROWS = 8 does not wrap to 0.
  assign row_ok     = ({1'b0, wr_row} < 4'(NUM_ROWS));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prio    <= 1'b0;
      bad_row <= 1'b0;
    end else begin
      if (gnt0)      prio <= 1'b1;
      else if (gnt1) prio <= 1'b0;
      bad_row <= wr_en & ~row_ok;
    end

  // ---------------- row stores ----------------
  // Writes are blocked during COMMIT, so copy and write never hit the same row
  // in one cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow  <= '0;
      display <= '0;
      pending <= '0;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (commit && pending[r]) begin
          display[r] <= shadow[r];
          pending[r] <= 1'b0;
        end
        if (wr_en && row_ok && wr_row == 3'(r)) begin
          shadow[r]  <= wr_data;
          pending[r] <= 1'b1;
        end
      end
    end

  // ---------------- scanline tracking ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y_prev   <= '0;
      line_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      y_prev <= y_px;
      if (y_px != y_prev) begin
        if (y_px == '0) begin
          line_cnt <= '0;
          row_cnt  <= '0;
        end else if (line_cnt == LW'(HEIGHT - 1)) begin
          line_cnt <= '0;
          if (row_cnt != 3'(NUM_ROWS - 1)) row_cnt <= row_cnt + 3'd1;
        end else begin
          line_cnt <= line_cnt + 1'b1;
        end
      end
    end

  always_comb begin
    cur_byte = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      if (row_cnt == 3'(r)) cur_byte = display[r];
  end

  // Drawer outputs hold outside active video.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_led  <= '0;
      byte_led <= '0;
    end else if (activevideo && !in_vblank) begin
      row_led  <= row_cnt;
      byte_led <= cur_byte;
    end

endmodule

// File: tb/tb_led_row_scheduler.sv
`timescale 1ns/1ps
// Directed bench for led_row_scheduler: frame-by-frame scan with a table of
// expected row/byte values per (frame, scanline), plus hand sequences for
// arbitration, bad rows, the COMMIT-cycle stall and mid-frame reset.
module tb_led_row_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] y_px;
  logic       activevideo;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_row, req1_row;
  logic [7:0] req0_byte, req1_byte;
  logic       req0_ready, req1_ready;
  logic [7:0] byte_led;
  logic [2:0] row_led;
  logic       commit, bad_row;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_row_scheduler #(.NUM_ROWS(6), .HEIGHT(80), .V_ACTIVE(480)) dut (
    .clk(clk), .rst_n(rst_n), .y_px(y_px), .activevideo(activevideo),
    .req0_valid(req0_valid), .req0_row(req0_row), .req0_byte(req0_byte),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_row(req1_row), .req1_byte(req1_byte),
    .req1_ready(req1_ready),
    .byte_led(byte_led), .row_led(row_led), .commit(commit), .bad_row(bad_row)
  );

  typedef struct {
    int         frame;
    logic [9:0] y;
    logic [2:0] row;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int f, int y, int r, int d);
    vec_t v;
    v.frame = f; v.y = 10'(y); v.row = 3'(r); v.data = 8'(d);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Apply a scanline at a negedge, then wait two cycles so the counter update
  // and the registered outputs have both happened.
  task automatic line(input int v);
    @(negedge clk);
    y_px        = 10'(v);
    activevideo = (v < 480);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int who, input logic [2:0] r, input logic [7:0] d, input string nm);
    if (who == 0) begin
      req0_valid = 1'b1; req0_row = r; req0_byte = d;
    end else begin
      req1_valid = 1'b1; req1_row = r; req1_byte = d;
    end
    #1 chk(nm, (who == 0) ? req0_ready : req1_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Vblank entry: commit visible one cycle after y_px reaches 480.
  task automatic vblank_entry(input bit late_write);
    @(negedge clk);
    y_px        = 10'd480;
    activevideo = 1'b0;
    @(negedge clk);
    #1 chk("commit_pulse", commit, 1);
    if (late_write) begin
      req0_valid = 1'b1; req0_row = 3'd5; req0_byte = 8'h77;
      #1 chk("ready_in_commit", req0_ready, 0);
      @(negedge clk);
      #1 chk("ready_after_commit", req0_ready, 1);
      chk("commit_falls", commit, 0);
      @(negedge clk);
      req0_valid = 1'b0;
    end else begin
      @(negedge clk);
      chk("commit_falls", commit, 0);
    end
    for (int v = 481; v < 525; v++) line(v);
  endtask

  initial begin
    logic [3:0] exp_r0, exp_r1;

    // frame 0: everything blank
    tbl.push_back(mk(0,   0, 0, 8'h00));
    tbl.push_back(mk(0,  80, 1, 8'h00));
    tbl.push_back(mk(0, 160, 2, 8'h00));
    tbl.push_back(mk(0, 239, 2, 8'h00));
    tbl.push_back(mk(0, 240, 3, 8'h00));
    tbl.push_back(mk(0, 320, 4, 8'h00));
    tbl.push_back(mk(0, 400, 5, 8'h00));
    tbl.push_back(mk(0, 479, 5, 8'h00));
    // frame 1: row 2 committed
    tbl.push_back(mk(1,   0, 0, 8'h00));
    tbl.push_back(mk(1,  80, 1, 8'h00));
    tbl.push_back(mk(1, 160, 2, 8'hA5));
    tbl.push_back(mk(1, 239, 2, 8'hA5));
    tbl.push_back(mk(1, 240, 3, 8'h00));
    tbl.push_back(mk(1, 320, 4, 8'h00));
    tbl.push_back(mk(1, 400, 5, 8'h00));
    // frame 2: arbitration results, last-wins, bad row ignored
    tbl.push_back(mk(2,   0, 0, 8'h00));
    tbl.push_back(mk(2,  80, 1, 8'h11));
    tbl.push_back(mk(2, 160, 2, 8'hA5));
    tbl.push_back(mk(2, 240, 3, 8'h33));
    tbl.push_back(mk(2, 320, 4, 8'hFF));
    tbl.push_back(mk(2, 400, 5, 8'h00));
    // frame 3: write made during COMMIT lands one frame later
    tbl.push_back(mk(3,   0, 0, 8'h00));
    tbl.push_back(mk(3, 320, 4, 8'hFF));
    tbl.push_back(mk(3, 400, 5, 8'h77));
    // frame 4: before mid-frame reset
    tbl.push_back(mk(4,  80, 1, 8'h11));
    tbl.push_back(mk(4, 240, 3, 8'h33));
    // frame 5: after reset every row is blank, pending row 0 discarded
    tbl.push_back(mk(5,   0, 0, 8'h00));
    tbl.push_back(mk(5,  80, 1, 8'h00));
    tbl.push_back(mk(5, 160, 2, 8'h00));
    tbl.push_back(mk(5, 400, 5, 8'h00));

    rst_n = 1'b0; y_px = '0; activevideo = 1'b1;
    req0_valid = 1'b0; req0_row = '0; req0_byte = '0;
    req1_valid = 1'b0; req1_row = '0; req1_byte = '0;
    #12;
    chk("rst_byte_led", byte_led, 0);
    chk("rst_row_led", row_led, 0);
    chk("rst_commit", commit, 0);
    chk("rst_bad_row", bad_row, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int f = 0; f < 6; f++) begin
      for (int v = 0; v < 480; v++) begin
        if (f == 5 && v > 420) break;
        line(v);
        chk("commit_low_active", commit, 0);
        foreach (tbl[i])
          if (tbl[i].frame == f && tbl[i].y == 10'(v)) begin
            chk($sformatf("row_led f%0d y%0d", f, v), row_led, tbl[i].row);
            chk($sformatf("byte_led f%0d y%0d", f, v), byte_led, tbl[i].data);
          end

        if (f == 0 && v == 100) wr(0, 3'd2, 8'hA5, "wr_row2_ready0");

        if (f == 1 && v == 10) begin
          wr(1, 3'd7, 8'h5A, "bad_row_ready1");
          chk("bad_row_pulse", bad_row, 1);
          @(negedge clk);
          chk("bad_row_single", bad_row, 0);
        end

        if (f == 1 && v == 50) begin
          req0_valid = 1'b1; req0_row = 3'd1; req0_byte = 8'h11;
          req1_valid = 1'b1; req1_row = 3'd3; req1_byte = 8'h33;
          exp_r0 = 4'b0001;
          exp_r1 = 4'b0010;
          for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("dual_ready0 c%0d", k), req0_ready, exp_r0[k]);
            chk($sformatf("dual_ready1 c%0d", k), req1_ready, exp_r1[k]);
            @(negedge clk);
            if (k == 0) req0_valid = 1'b0;
            if (k == 1) req1_valid = 1'b0;
          end
        end

        if (f == 1 && v == 60) begin
          wr(0, 3'd4, 8'h01, "row4_first");
          wr(0, 3'd4, 8'hFF, "row4_second");
        end

        if (f == 4 && v == 200) wr(1, 3'd0, 8'h99, "pending_row0");

        if (f == 4 && v == 250) begin
          chk("pre_reset_row_led", row_led, 3);
          chk("pre_reset_byte_led", byte_led, 8'h33);
          rst_n = 1'b0;
          #1;
          chk("midrst_byte_led", byte_led, 0);
          chk("midrst_row_led", row_led, 0);
          chk("midrst_commit", commit, 0);
          chk("midrst_bad_row", bad_row, 0);
          chk("midrst_ready0", req0_ready, 0);
          chk("midrst_ready1", req1_ready, 0);
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
      if (f < 5) vblank_entry(f == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
